mtrx_slice_streamer: RTL and testbench
======================================

# mtrx_slice_streamer

Parametrised, synthesizable multi-channel matrix slice source for the systolic array. It holds matrix data in an internal byte-addressable memory loaded through a write port. On command, each channel streams a contiguous slice (base, length) to its consumer under a valid/ready handshake, with a last-beat flag and a done pulse. It replaces the fixed two-matrix, fixed-length simulation generator and feeds the MtrxA/MtrxB (and further) slice inputs of the array.

## Interface
- DATA_W, 8: slice word width (bits).
- ADDR_W, 12: memory address width; depth = 2^ADDR_W words.
- LEN_W, 10: slice length field width; max slice = 2^LEN_W − 1 words.
- NUM_CH, 2: number of independent read channels; channel 0 = MtrxA, channel 1 = MtrxB.

- s_clk  in  1  sole clock, rising edge.
- s_rst  in  1  synchronous, active-high reset.
- mem_wr_en  in  1  memory write strobe.
- mem_wr_addr  in  ADDR_W  write address.
- mem_wr_data  in  DATA_W  write data.
- start  in  NUM_CH  per-channel start request; accepted only when that channel is idle.
- start_base  in  NUM_CH*ADDR_W  per-channel slice base address; channel c occupies bits [c*ADDR_W +: ADDR_W].
- start_len  in  NUM_CH*LEN_W  per-channel slice length in words.
- busy  out  NUM_CH  channel not idle.
- slice_valid  out  NUM_CH  output word valid.
- slice_data  out  NUM_CH*DATA_W  output word.
- slice_last  out  NUM_CH  current word is the final word of the slice.
- slice_ready  in  NUM_CH  consumer accepts the word.
- slice_done  out  NUM_CH  one-cycle pulse; slice complete.

## Operation
- Memory: 2^ADDR_W × DATA_W array with one write port and NUM_CH synchronous read ports (1-cycle read latency). The array is not reset; contents survive s_rst. A read and a write to the same address in the same cycle return the old data.
- Per-channel FSM with two states:
  - IDLE → RUN when start[c] is high and start_len[c] ≠ 0. Base and length are latched on that edge.
  - start[c] with start_len[c] = 0 in IDLE: the FSM stays in IDLE; slice_done[c] pulses on the next cycle; no beat is emitted.
  - RUN → IDLE on the cycle the beat with slice_last is accepted (valid & ready).
  - start[c] in RUN is ignored.
- Address generation: read address = base + beat index, modulo 2^ADDR_W (wraps past the top of memory).
- Output stage: a 2-entry skid buffer per channel.
  - Sustains one beat per cycle while slice_ready is held high.
  - Memory prefetch is stopped when the buffer cannot take an in-flight read.
- Handshake rules:
  - Once slice_valid rises, slice_valid, slice_data and slice_last hold stable until accepted.
  - slice_valid never drops without an acceptance, except on s_rst.
- Exactly start_len beats are emitted per slice; slice_last is high only on beat start_len−1.
- busy[c] is high from the cycle after start acceptance until slice_done[c] is asserted, inclusive.
- Channels are fully independent; simultaneous starts on all channels are legal.

## Timing
- Reset values: slice_valid = 0, slice_last = 0, slice_done = 0, busy = 0, slice_data = 0. All FSMs are in IDLE and all counters are 0.
- Start accepted at edge T → busy = 1 from T+1 → slice_valid = 1 with word[base] at T+2 (latency 2).
- With slice_ready held high: beat k is presented at T+2+k. The last beat is accepted at T+1+len. slice_done pulses at T+2+len, and busy falls at T+3+len.
- A new start is accepted in the cycle busy = 0.
- A slice_ready deassertion of any length loses no beats and duplicates none; streaming resumes on the cycle ready returns high.
- s_rst asserted mid-slice: at the next edge all outputs return to reset values and the slice is abandoned. No done pulse is generated.
- mem_wr takes effect at the edge: data written at edge W is readable by a read issued at edge W+1 or later.

## Configuration
- SLICE_STREAM_REPEAT_EN defined:
  - Adds input start_repeat, NUM_CH*4 bits.
  - The latched slice is streamed start_repeat+1 times back-to-back. The address restarts at base with no bubble.
  - slice_last asserts on the final beat of every pass. slice_done pulses once, after the final pass only.
- Not defined:
  - Port absent; each slice is streamed exactly once.

## Test plan
- Load mem[0..255] = addr[7:0]; ch0 start base=0 len=256, ready always high → 256 beats with data 0..255 on consecutive cycles; slice_last on beat 255; slice_done at T+258.
- ch0 base=0 len=16 and ch1 base=2048 len=16, started in the same cycle; ch1 ready toggled 1/0 → ch0 completes at T+18; ch1 emits exactly 16 in-order beats with data held stable while stalled.
- base=4094 len=4 → data from addresses 4094, 4095, 0, 1.
- len=0 start → no slice_valid; slice_done pulses at T+1; busy stays 0.
- s_rst asserted at beat 5 of a len=32 slice → all outputs 0 at the next edge; no slice_done. Restart base=0 len=4 → beats 0..3 with the memory unchanged.
- With SLICE_STREAM_REPEAT_EN: len=3, start_repeat=2 → 9 consecutive beats (0,1,2 ×3); slice_last on beats 2, 5 and 8; one slice_done.

Source files
------------

// File: rtl/mtrx_slice_streamer.sv
// mtrx_slice_streamer: multi-channel matrix slice source for the systolic array.
// A shared byte-addressable memory (one write port, NUM_CH read ports) holds the
// matrix data. Each channel streams a (base, length) slice under valid/ready,
// flags the final beat and pulses done when the slice completes.
// Optional feature macro: SLICE_STREAM_REPEAT_EN adds start_repeat, which
// replays the latched slice start_repeat+1 times back-to-back.
module mtrx_slice_streamer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10,
    parameter int NUM_CH = 2
) (
    input  logic                     s_clk,
    input  logic                     s_rst,
    input  logic                     mem_wr_en,
    input  logic [ADDR_W-1:0]        mem_wr_addr,
    input  logic [DATA_W-1:0]        mem_wr_data,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH*ADDR_W-1:0] start_base,
    input  logic [NUM_CH*LEN_W-1:0]  start_len,
`ifdef SLICE_STREAM_REPEAT_EN
    input  logic [NUM_CH*4-1:0]      start_repeat,
`endif
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        slice_valid,
    output logic [NUM_CH*DATA_W-1:0] slice_data,
    output logic [NUM_CH-1:0]        slice_last,
    input  logic [NUM_CH-1:0]        slice_ready,
    output logic [NUM_CH-1:0]        slice_done
);

    typedef enum logic {IDLE, RUN} chState_t;

    logic [DATA_W-1:0] memArray [0:(2**ADDR_W)-1];

    // Shared write port; contents deliberately survive reset.
    always_ff @(posedge s_clk) begin
        if (mem_wr_en) begin
            memArray[mem_wr_addr] <= mem_wr_data;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        chState_t          state, nextState;
        logic [ADDR_W-1:0] baseLat;
        logic [LEN_W-1:0]  lenLat;
        logic [3:0]        repLat;
        logic [3:0]        repIn;
        logic [LEN_W-1:0]  lenIn;
        logic [LEN_W-1:0]  issueIdx;
        logic [3:0]        passCnt;
        logic              issueDone;
        logic              busyReg, doneReg, zeroPend;
        logic              startOk, acceptGo, acceptZero;
        logic              issue, issueIdxLast, issueFinal;
        logic [ADDR_W-1:0] rdAddr;
        logic [ADDR_W-1:0] rdAddr_p0;
        logic              rdVld_p0, rdLast_p0, rdFin_p0;
        logic [1:0]        bufCnt;
        logic [DATA_W-1:0] bufData0_p1, bufData1_p1;
        logic              bufLast0_p1, bufLast1_p1, bufFin0_p1, bufFin1_p1;
        logic              outVld, pop, push, popFinal;
        logic              ld0New, ld0Shift, ld1New;

`ifdef SLICE_STREAM_REPEAT_EN
        assign repIn = start_repeat[c*4 +: 4];
`else
        assign repIn = 4'd0;
`endif
        assign lenIn      = start_len[c*LEN_W +: LEN_W];
        assign startOk    = start[c] && (state == IDLE) && !busyReg;
        assign acceptGo   = startOk && (lenIn != '0);
        assign acceptZero = startOk && (lenIn == '0);

        assign outVld   = (bufCnt != 2'd0);
        assign pop      = outVld && slice_ready[c];
        assign popFinal = pop && bufFin0_p1;
        assign push     = rdVld_p0;

        assign issueIdxLast = (issueIdx == lenLat - LEN_W'(1));
        assign issueFinal   = issueIdxLast && (passCnt == repLat);
        assign rdAddr       = baseLat + ADDR_W'(issueIdx);
        // A read may be issued only if the buffer can still hold it together
        // with any read already in flight, after this cycle's pop.
        assign issue = (state == RUN) && !issueDone &&
                       (({1'b0, bufCnt} + {2'b0, rdVld_p0}) <= (3'd1 + {2'b0, pop}));

        assign ld0New   = push && ((bufCnt == 2'd0) || ((bufCnt == 2'd1) && pop));
        assign ld0Shift = pop && (bufCnt == 2'd2);
        assign ld1New   = push && (((bufCnt == 2'd1) && !pop) || ((bufCnt == 2'd2) && pop));

        // Next-state: leave RUN only when the final beat of the final pass is taken.
        always_comb begin
            nextState = state;
            case (state)
                IDLE:    if (acceptGo) nextState = RUN;
                RUN:     if (popFinal) nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end

        // Control state: FSM, counters, read-pipeline valid and buffer flags.
        always_ff @(posedge s_clk) begin
            if (s_rst) begin
                state       <= IDLE;
                busyReg     <= 1'b0;
                doneReg     <= 1'b0;
                zeroPend    <= 1'b0;
                lenLat      <= '0;
                repLat      <= '0;
                issueIdx    <= '0;
                passCnt     <= '0;
                issueDone   <= 1'b0;
                rdVld_p0    <= 1'b0;
                rdLast_p0   <= 1'b0;
                rdFin_p0    <= 1'b0;
                bufCnt      <= 2'd0;
                bufLast0_p1 <= 1'b0;
                bufLast1_p1 <= 1'b0;
                bufFin0_p1  <= 1'b0;
                bufFin1_p1  <= 1'b0;
            end else begin
                state    <= nextState;
                busyReg  <= (state == RUN);
                zeroPend <= acceptZero;
                doneReg  <= popFinal || zeroPend;
                if (acceptGo) begin
                    lenLat    <= lenIn;
                    repLat    <= repIn;
                    issueIdx  <= '0;
                    passCnt   <= '0;
                    issueDone <= 1'b0;
                end else if (issue) begin
                    if (issueIdxLast) begin
                        issueIdx <= '0;
                        if (issueFinal) issueDone <= 1'b1;
                        else            passCnt   <= passCnt + 4'd1;
                    end else begin
                        issueIdx <= issueIdx + LEN_W'(1);
                    end
                end
                // address stage -> read stage
                rdVld_p0  <= issue;
                rdLast_p0 <= issueIdxLast;
                rdFin_p0  <= issueFinal;
                // read stage -> skid buffer
                bufCnt <= bufCnt + 2'(push) - 2'(pop);
                if (ld0New) begin
                    bufLast0_p1 <= rdLast_p0;
                    bufFin0_p1  <= rdFin_p0;
                end else if (ld0Shift) begin
                    bufLast0_p1 <= bufLast1_p1;
                    bufFin0_p1  <= bufFin1_p1;
                end
                if (ld1New) begin
                    bufLast1_p1 <= rdLast_p0;
                    bufFin1_p1  <= rdFin_p0;
                end
            end
        end

        // Datapath: latched base, registered read address and buffered words.
        always_ff @(posedge s_clk) begin
            if (acceptGo) baseLat <= start_base[c*ADDR_W +: ADDR_W];
            rdAddr_p0 <= rdAddr;
            if (ld0New)        bufData0_p1 <= memArray[rdAddr_p0];
            else if (ld0Shift) bufData0_p1 <= bufData1_p1;
            if (ld1New)        bufData1_p1 <= memArray[rdAddr_p0];
        end

        assign busy[c]        = busyReg;
        assign slice_done[c]  = doneReg;
        assign slice_valid[c] = outVld;
        assign slice_last[c]  = outVld && bufLast0_p1;
        assign slice_data[c*DATA_W +: DATA_W] = outVld ? bufData0_p1 : '0;
    end

endmodule

// File: tb/tb_mtrx_slice_streamer.sv
// tb_mtrx_slice_streamer: directed self-checking bench for mtrx_slice_streamer.
// Covers reset values, a full 256-word slice, two simultaneous channels with
// back-pressure, address wrap, zero-length start, mid-slice reset and, when
// SLICE_STREAM_REPEAT_EN is defined, slice replay.
`timescale 1ns/1ps
module tb_mtrx_slice_streamer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 10;
    localparam int NUM_CH = 2;

    logic                     s_clk = 1'b0;
    logic                     s_rst;
    logic                     mem_wr_en;
    logic [ADDR_W-1:0]        mem_wr_addr;
    logic [DATA_W-1:0]        mem_wr_data;
    logic [NUM_CH-1:0]        start;
    logic [NUM_CH*ADDR_W-1:0] start_base;
    logic [NUM_CH*LEN_W-1:0]  start_len;
`ifdef SLICE_STREAM_REPEAT_EN
    logic [NUM_CH*4-1:0]      start_repeat;
`endif
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        slice_valid;
    logic [NUM_CH*DATA_W-1:0] slice_data;
    logic [NUM_CH-1:0]        slice_last;
    logic [NUM_CH-1:0]        slice_ready;
    logic [NUM_CH-1:0]        slice_done;

    mtrx_slice_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .NUM_CH(NUM_CH)
    ) dut (
        .s_clk(s_clk),
        .s_rst(s_rst),
        .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .start(start),
        .start_base(start_base),
        .start_len(start_len),
`ifdef SLICE_STREAM_REPEAT_EN
        .start_repeat(start_repeat),
`endif
        .busy(busy),
        .slice_valid(slice_valid),
        .slice_data(slice_data),
        .slice_last(slice_last),
        .slice_ready(slice_ready),
        .slice_done(slice_done)
    );

    always #5 s_clk = ~s_clk;

    int         nChecks = 0;
    int         nErrors = 0;
    logic [7:0] memModel [0:4095];
    int         n0, n1, d0, d1, dCnt;
    logic       prevStall;
    logic [9:0] prevData;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic writeWord(input int addr, input logic [7:0] d);
        mem_wr_en   = 1'b1;
        mem_wr_addr = ADDR_W'(addr);
        mem_wr_data = d;
        memModel[addr] = d;
        @(negedge s_clk);
        mem_wr_en = 1'b0;
    endtask

    task automatic startCh(input int ch, input int base, input int len);
        start = '0;
        start[ch] = 1'b1;
        start_base[ch*ADDR_W +: ADDR_W] = ADDR_W'(base);
        start_len[ch*LEN_W +: LEN_W]    = LEN_W'(len);
    endtask

    // Start a slice on one channel with ready held high and check every beat,
    // the done pulse and busy against the nominal timeline.
    task automatic streamCheck(input int ch, input int base, input int len, input int rep,
                               input string tag);
        int total;
        int idx;
        total = len * (rep + 1);
        startCh(ch, base, len);
`ifdef SLICE_STREAM_REPEAT_EN
        start_repeat[ch*4 +: 4] = 4'(rep);
`endif
        @(negedge s_clk);
        start = '0;
        checkEq({tag, "_busyT"}, {31'd0, busy[ch]}, 32'd0);
        @(negedge s_clk);
        checkEq({tag, "_T1"}, {30'd0, busy[ch], slice_valid[ch]}, 32'b10);
        for (int k = 0; k < total; k++) begin
            @(negedge s_clk);
            idx = k % len;
            checkEq({tag, "_beat"},
                    {21'd0, slice_valid[ch], slice_last[ch], slice_done[ch], slice_data[ch*DATA_W +: DATA_W]},
                    {21'd0, 1'b1, (idx == len - 1), 1'b0, memModel[(base + idx) % 4096]});
        end
        @(negedge s_clk);
        checkEq({tag, "_done"}, {29'd0, slice_done[ch], busy[ch], slice_valid[ch]}, 32'b110);
        @(negedge s_clk);
        checkEq({tag, "_idle"}, {30'd0, slice_done[ch], busy[ch]}, 32'b00);
    endtask

    initial begin
        s_rst       = 1'b1;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        start       = '0;
        start_base  = '0;
        start_len   = '0;
        slice_ready = '1;
`ifdef SLICE_STREAM_REPEAT_EN
        start_repeat = '0;
`endif
        repeat (3) @(negedge s_clk);
        checkEq("rst_ctl", {24'd0, busy, slice_valid, slice_last, slice_done}, 32'd0);
        checkEq("rst_data", {16'd0, slice_data}, 32'd0);
        s_rst = 1'b0;

        for (int i = 0; i < 256; i++) writeWord(i, 8'(i));
        for (int i = 0; i < 16; i++)  writeWord(2048 + i, 8'(8'hA0 + i));
        writeWord(4094, 8'hFE);
        writeWord(4095, 8'hFF);

        // full 256-word slice at one beat per cycle
        streamCheck(0, 0, 256, 0, "t1");

        // both channels together, ch1 back-pressured every other cycle
        start      = 2'b11;
        start_base = {12'd2048, 12'd0};
        start_len  = {10'd16, 10'd16};
        n0 = 0; n1 = 0; d0 = 0; d1 = 0;
        prevStall = 1'b0;
        prevData  = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge s_clk);
            start = '0;
            if (slice_done[0]) begin
                d0++;
                checkEq("t2_done0_cycle", i, 18);
            end
            if (slice_done[1]) d1++;
            if (slice_valid[0]) begin
                checkEq("t2_ch0", {23'd0, slice_last[0], slice_data[7:0]}, {23'd0, (n0 == 15), 8'(n0)});
                n0++;
            end
            if (prevStall)
                checkEq("t2_hold", {22'd0, slice_valid[1], slice_last[1], slice_data[15:8]}, {22'd0, prevData});
            slice_ready[1] = (i % 2 == 1);
            if (slice_valid[1]) begin
                if (slice_ready[1]) begin
                    checkEq("t2_ch1", {23'd0, slice_last[1], slice_data[15:8]},
                            {23'd0, (n1 == 15), memModel[2048 + (n1 % 16)]});
                    n1++;
                    prevStall = 1'b0;
                end else begin
                    prevStall = 1'b1;
                    prevData  = {1'b1, slice_last[1], slice_data[15:8]};
                end
            end else begin
                prevStall = 1'b0;
            end
        end
        slice_ready = '1;
        checkEq("t2_n0", n0, 16);
        checkEq("t2_n1", n1, 16);
        checkEq("t2_d0", d0, 1);
        checkEq("t2_d1", d1, 1);

        // address wrap past the top of memory
        streamCheck(0, 4094, 4, 0, "t3");

        // zero-length start: done only, no beats, busy stays low
        startCh(1, 0, 0);
        @(negedge s_clk);
        start = '0;
        checkEq("t4_T", {29'd0, slice_done[1], busy[1], slice_valid[1]}, 32'b000);
        @(negedge s_clk);
        checkEq("t4_T1", {29'd0, slice_done[1], busy[1], slice_valid[1]}, 32'b100);
        @(negedge s_clk);
        checkEq("t4_T2", {29'd0, slice_done[1], busy[1], slice_valid[1]}, 32'b000);

        // reset in the middle of a slice, then restart from the kept memory
        startCh(0, 0, 32);
        @(negedge s_clk);
        start = '0;
        repeat (7) @(negedge s_clk);
        checkEq("t5_beat5", {23'd0, slice_valid[0], slice_data[7:0]}, {23'd0, 1'b1, 8'd5});
        s_rst = 1'b1;
        @(negedge s_clk);
        checkEq("t5_rst_ctl", {24'd0, busy, slice_valid, slice_last, slice_done}, 32'd0);
        checkEq("t5_rst_data", {16'd0, slice_data}, 32'd0);
        s_rst = 1'b0;
        dCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge s_clk);
            if (slice_done != '0 || slice_valid != '0) dCnt++;
        end
        checkEq("t5_quiet", dCnt, 0);
        streamCheck(0, 0, 4, 0, "t5r");

`ifdef SLICE_STREAM_REPEAT_EN
        // three passes of a three-word slice, one done at the end
        streamCheck(0, 0, 3, 2, "t6");
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
